// File: rtl/img_pkg.sv
// Shared definitions for the window-based streaming image filters.
// Holds the sync bundle type, kernel-size legality check and window index helper.
package img_pkg;

    typedef struct packed {
        logic vsync;
        logic hsync;
        logic clken;
    } sync_t;

    function automatic bit ksize_legal(input int k);
        return (k == 3) || (k == 5);
    endfunction

    // Flat element index of window position (r,c) for a k-by-k kernel.
    function automatic int win_idx(input int r, input int c, input int k);
        return r * k + c;
    endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// Simple dual-port line RAM with a registered, read-before-write read port.
// Contents are not reset; consumers mask data they have not written.
module line_buffer_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 640,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        if (wr_en) mem[wr_addr] <= wr_data;
    end

endmodule

// File: rtl/matrix_window_gen.sv
// K-by-K sliding window generator: cascaded line buffers, zero top/left border,
// two-stage pipeline with the frame syncs delayed to stay aligned with the window.
module matrix_window_gen
    import img_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 640,
    parameter int KSIZE  = 3,
    parameter int ROW_W  = 11
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            vsync_i,
    input  logic                            hsync_i,
    input  logic                            clk_en_i,
    input  logic [DATA_W-1:0]               data_i,
    output logic                            matrix_frame_vsync,
    output logic                            matrix_frame_hsync,
    output logic                            matrix_frame_clken,
    output logic [KSIZE*KSIZE*DATA_W-1:0]   matrix_o,
    output logic                            matrix_win_valid
);

    localparam int AW = $clog2(IMG_W);
    // One extra bit so pixels past IMG_W are recognised instead of wrapping onto stored columns.
    localparam int CW = AW + 1;
    localparam int NB = KSIZE - 1;

    if (!ksize_legal(KSIZE) || IMG_W < KSIZE) begin : g_param_err
        $error("matrix_window_gen: KSIZE must be 3 or 5 and IMG_W must be >= KSIZE");
    end

    logic              vsync_q, hsync_q, row_hold;
    logic              accept, vs_rise, hs_fall;
    logic [CW-1:0]     col_cnt;
    logic [ROW_W-1:0]  row_cnt;

    assign accept  = clk_en_i & hsync_i;
    assign vs_rise = vsync_i & ~vsync_q;
    assign hs_fall = hsync_q & ~hsync_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q  <= 1'b0;
            hsync_q  <= 1'b0;
            row_hold <= 1'b0;
            col_cnt  <= '0;
            row_cnt  <= '0;
        end else begin
            vsync_q <= vsync_i;
            hsync_q <= hsync_i;
            if (hs_fall)
                col_cnt <= '0;
            else if (accept && col_cnt != '1)
                col_cnt <= col_cnt + 1'b1;
            // A frame start inside a line makes the following line row 0.
            if (vs_rise) begin
                row_cnt  <= '0;
                row_hold <= hsync_i;
            end else if (hs_fall) begin
                if (row_hold)
                    row_hold <= 1'b0;
                else if (row_cnt != '1)
                    row_cnt <= row_cnt + 1'b1;
            end
        end
    end

    sync_t             sync_d1, sync_d2;
    logic              acc_s1;
    logic [CW-1:0]     col_s1;
    logic [ROW_W-1:0]  row_s1;
    logic [DATA_W-1:0] data_s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_d1 <= '0;
            acc_s1  <= 1'b0;
            col_s1  <= '0;
            row_s1  <= '0;
            data_s1 <= '0;
        end else begin
            sync_d1 <= {vsync_i, hsync_i, clk_en_i};
            acc_s1  <= accept;
            if (accept) begin
                col_s1  <= col_cnt;
                row_s1  <= row_cnt;
                data_s1 <= data_i;
            end
        end
    end

    logic [DATA_W-1:0] rd_data [NB];
    logic              wr_en;

    assign wr_en = acc_s1 && (col_s1 < CW'(IMG_W));

    // Reads happen with the live column; the write-back of the shifted line follows one cycle later.
    for (genvar k = 0; k < NB; k++) begin : g_lb
        logic [DATA_W-1:0] wr_data;
        if (k == 0) begin : g_first
            assign wr_data = data_s1;
        end else begin : g_next
            assign wr_data = rd_data[k-1];
        end
        line_buffer_ram #(
            .DATA_W (DATA_W),
            .DEPTH  (IMG_W)
        ) u_ram (
            .clk     (clk),
            .rd_en   (accept),
            .rd_addr (col_cnt[AW-1:0]),
            .rd_data (rd_data[k]),
            .wr_en   (wr_en),
            .wr_addr (col_s1[AW-1:0]),
            .wr_data (wr_data)
        );
    end

    logic [DATA_W-1:0] tap [KSIZE];

    for (genvar r = 0; r < KSIZE; r++) begin : g_tap
        localparam int DIST = KSIZE - 1 - r;
        logic [DATA_W-1:0] src;
        if (DIST == 0) begin : g_new
            assign src = data_s1;
        end else begin : g_old
            assign src = rd_data[DIST-1];
        end
        assign tap[r] = (row_s1 < ROW_W'(DIST)) ? '0 : src;
    end

    logic [DATA_W-1:0] win [KSIZE][KSIZE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < KSIZE; r++)
                for (int c = 0; c < KSIZE; c++)
                    win[r][c] <= '0;
            sync_d2          <= '0;
            matrix_win_valid <= 1'b0;
        end else begin
            sync_d2          <= sync_d1;
            matrix_win_valid <= acc_s1 && (col_s1 >= CW'(KSIZE-1)) && (row_s1 >= ROW_W'(KSIZE-1));
            if (!sync_d1.hsync) begin
                for (int r = 0; r < KSIZE; r++)
                    for (int c = 0; c < KSIZE; c++)
                        win[r][c] <= '0;
            end else if (acc_s1) begin
                for (int r = 0; r < KSIZE; r++) begin
                    for (int c = 0; c < KSIZE-1; c++)
                        win[r][c] <= win[r][c+1];
                    win[r][KSIZE-1] <= tap[r];
                end
            end
        end
    end

    for (genvar r = 0; r < KSIZE; r++) begin : g_out_r
        for (genvar c = 0; c < KSIZE; c++) begin : g_out_c
            assign matrix_o[win_idx(r, c, KSIZE)*DATA_W +: DATA_W] = win[r][c];
        end
    end

    assign matrix_frame_vsync = sync_d2.vsync;
    assign matrix_frame_hsync = sync_d2.hsync;
    assign matrix_frame_clken = sync_d2.clken;

endmodule

// File: tb/tb_matrix_window_gen.sv
// Bench for matrix_window_gen: 3x3 and 5x5 instances share one pixel stream and are
// compared against a frame-array model of what each window position should contain.
module tb_matrix_window_gen;

    localparam int DW = 16;
    localparam int IW = 8;
    localparam int RW = 11;

    typedef struct packed {
        logic          vs;
        logic          hs;
        logic          ce;
        logic [DW-1:0] d;
    } stim_t;

    typedef struct {
        logic [143:0] w3, k3;
        logic [399:0] w5, k5;
        logic         v3, v5;
        logic [2:0]   sync;
        int           r, c;
        bit           acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, vsync, hsync, clken;
    logic [DW-1:0] data;
    logic fv3, fh3, fc3, v3, fv5, fh5, fc5, v5;
    logic [9*DW-1:0]  m3;
    logic [25*DW-1:0] m5;

    int n_checks = 0;
    int n_pass   = 0;

    int pix [16][16];
    int len [16];
    int m_r, m_c;
    bit m_vs_q, m_hs_q;
    logic [143:0] mw3, mk3;
    logic [399:0] mw5, mk5;
    exp_t p, e;
    stim_t sq [$];

    always #5 clk = ~clk;

    matrix_window_gen #(.DATA_W(DW), .IMG_W(IW), .KSIZE(3), .ROW_W(RW)) dut3 (
        .clk(clk), .rst_n(rst_n), .vsync_i(vsync), .hsync_i(hsync), .clk_en_i(clken),
        .data_i(data), .matrix_frame_vsync(fv3), .matrix_frame_hsync(fh3),
        .matrix_frame_clken(fc3), .matrix_o(m3), .matrix_win_valid(v3));

    matrix_window_gen #(.DATA_W(DW), .IMG_W(IW), .KSIZE(5), .ROW_W(RW)) dut5 (
        .clk(clk), .rst_n(rst_n), .vsync_i(vsync), .hsync_i(hsync), .clk_en_i(clken),
        .data_i(data), .matrix_frame_vsync(fv5), .matrix_frame_hsync(fh5),
        .matrix_frame_clken(fc5), .matrix_o(m5), .matrix_win_valid(v5));

    // Window expected for the pixel at (r,c); mask bits are clear where the line RAM content is unknown.
    function automatic void model_win(input int k, input int r, input int c,
                                      output logic [399:0] w, output logic [399:0] msk);
        w   = '0;
        msk = '0;
        for (int i = 0; i < k; i++) begin
            for (int j = 0; j < k; j++) begin
                int  sr, sc, idx, val;
                bit  known;
                sr = r - (k - 1 - i);
                sc = c - (k - 1 - j);
                idx = (i * k + j) * DW;
                known = 1'b1;
                val = 0;
                if (sr < 0 || sc < 0) begin
                    val = 0;
                end else if (sr == r) begin
                    val = pix[r][sc];
                end else begin
                    known = (sc < IW);
                    for (int q = sr; q < r; q++)
                        if (len[q] <= sc) known = 1'b0;
                    val = pix[sr][sc];
                end
                if (known) begin
                    w[idx +: DW]   = val[DW-1:0];
                    msk[idx +: DW] = '1;
                end
            end
        end
    endfunction

    task automatic model_reset();
        m_r = 0; m_c = 0; m_vs_q = 1'b0; m_hs_q = 1'b0;
        mw3 = '0; mk3 = '1; mw5 = '0; mk5 = '1;
        p.w3 = '0; p.k3 = '1; p.w5 = '0; p.k5 = '1;
        p.v3 = 1'b0; p.v5 = 1'b0; p.sync = '0; p.r = 0; p.c = 0; p.acc = 1'b0;
        e = p;
    endtask

    // Applies one cycle of input; afterwards e holds the expectation for what the DUTs now show.
    task automatic step(input stim_t s);
        exp_t n;
        logic [399:0] w, k;
        vsync = s.vs; hsync = s.hs; clken = s.ce; data = s.d;
        if (s.vs && !m_vs_q) m_r = 0;
        n.sync = {s.vs, s.hs, s.ce};
        n.acc  = s.hs && s.ce;
        n.r = m_r; n.c = m_c; n.v3 = 1'b0; n.v5 = 1'b0;
        if (n.acc) begin
            pix[m_r][m_c] = int'(s.d);
            model_win(3, m_r, m_c, w, k); mw3 = w[143:0]; mk3 = k[143:0];
            model_win(5, m_r, m_c, w, k); mw5 = w; mk5 = k;
            n.v3 = (m_c >= 2) && (m_r >= 2);
            n.v5 = (m_c >= 4) && (m_r >= 4);
            m_c++;
        end else if (!s.hs) begin
            mw3 = '0; mk3 = '1; mw5 = '0; mk5 = '1;
        end
        n.w3 = mw3; n.k3 = mk3; n.w5 = mw5; n.k5 = mk5;
        if (m_hs_q && !s.hs) begin
            len[m_r] = m_c;
            m_r++;
            m_c = 0;
        end
        m_vs_q = s.vs; m_hs_q = s.hs;
        @(posedge clk); #1;
        e = p;
        p = n;
    endtask

    task automatic push_vsync();
        sq.push_back({3'b100, 16'h0});
        sq.push_back('0);
    endtask

    task automatic push_line(input int row, input int n, input int gap_at, input int gap_len, input bit rnd);
        for (int c = 0; c < n; c++) begin
            if (c == gap_at)
                for (int g = 0; g < gap_len; g++) sq.push_back({3'b010, 16'h0});
            sq.push_back({3'b011, rnd ? 16'($urandom) : 16'(row * 16 + c)});
        end
        sq.push_back('0);
        sq.push_back('0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vsync = 1'b0; hsync = 1'b0; clken = 1'b0; data = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (m3 !== '0 || m5 !== '0 || {fv3, fh3, fc3, v3, fv5, fh5, fc5, v5} !== 8'h00)
            $display("FAIL reset: m3=%h m5=%h flags=%b, want all zero", m3, m5, {fv3, fh3, fc3, v3, fv5, fh5, fc5, v5});
        else n_pass++;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_first_frame();
        logic [143:0] ref_w;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) ref_w[(i*3+j)*DW +: DW] = 16'(i * 16 + j);
        sq.delete();
        push_vsync();
        for (int r = 0; r < 4; r++) push_line(r, 8, -1, 0, 1'b0);
        foreach (sq[i]) begin
            step(sq[i]);
            n_checks++;
            if ((m3 & e.k3) !== (e.w3 & e.k3) || v3 !== e.v3 || {fv3, fh3, fc3} !== e.sync)
                $display("FAIL first_frame r%0d c%0d: mat=%h valid=%b sync=%b want mat=%h valid=%b sync=%b",
                         e.r, e.c, m3, v3, {fv3, fh3, fc3}, e.w3, e.v3, e.sync);
            else n_pass++;
            if (e.acc && e.r == 2 && e.c == 2) begin
                n_checks++;
                if (m3 !== ref_w || v3 !== 1'b1)
                    $display("FAIL first_frame_r2c2: mat=%h valid=%b want mat=%h valid=1", m3, v3, ref_w);
                else n_pass++;
            end
            if (e.acc && e.r == 2 && e.c == 1) begin
                n_checks++;
                if (v3 !== 1'b0) $display("FAIL first_frame_r2c1_valid: got %b want 0", v3);
                else n_pass++;
            end
        end
    endtask

    task automatic test_second_frame();
        sq.delete();
        push_vsync();
        for (int r = 0; r < 2; r++) push_line(r, 8, -1, 0, 1'b0);
        foreach (sq[i]) begin
            step(sq[i]);
            n_checks++;
            if ((m3 & e.k3) !== (e.w3 & e.k3) || v3 !== e.v3 || {fv3, fh3, fc3} !== e.sync)
                $display("FAIL second_frame r%0d c%0d: mat=%h valid=%b sync=%b want mat=%h valid=%b sync=%b",
                         e.r, e.c, m3, v3, {fv3, fh3, fc3}, e.w3, e.v3, e.sync);
            else n_pass++;
            if (e.acc && e.r == 0) begin
                n_checks++;
                if (m3[95:0] !== 96'h0) $display("FAIL second_frame_row0_top: got %h want 0", m3[95:0]);
                else n_pass++;
            end
            if (e.acc && e.r == 1 && e.c == 2) begin
                n_checks++;
                if (m3[47:0] !== 48'h0) $display("FAIL second_frame_r1c2_top: got %h want 0", m3[47:0]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_clken_gap();
        int gaps = 0;
        sq.delete();
        push_vsync();
        push_line(0, 8, -1, 0, 1'b0);
        push_line(1, 8, -1, 0, 1'b0);
        push_line(2, 8, 4, 3, 1'b0);
        foreach (sq[i]) begin
            step(sq[i]);
            if (fh3 && !fc3) gaps++;
            n_checks++;
            if ((m3 & e.k3) !== (e.w3 & e.k3) || v3 !== e.v3 || {fv3, fh3, fc3} !== e.sync)
                $display("FAIL clken_gap r%0d c%0d: mat=%h valid=%b sync=%b want mat=%h valid=%b sync=%b",
                         e.r, e.c, m3, v3, {fv3, fh3, fc3}, e.w3, e.v3, e.sync);
            else n_pass++;
        end
        n_checks++;
        if (gaps !== 3) $display("FAIL clken_gap_count: got %0d low cycles want 3", gaps);
        else n_pass++;
    endtask

    task automatic test_long_line();
        sq.delete();
        push_vsync();
        push_line(0, 10, -1, 0, 1'b0);
        push_line(1, 10, -1, 0, 1'b0);
        push_line(2, 8, -1, 0, 1'b0);
        foreach (sq[i]) begin
            step(sq[i]);
            n_checks++;
            if ((m3 & e.k3) !== (e.w3 & e.k3) || v3 !== e.v3 || {fv3, fh3, fc3} !== e.sync)
                $display("FAIL long_line r%0d c%0d: mat=%h valid=%b sync=%b want mat=%h valid=%b sync=%b",
                         e.r, e.c, m3, v3, {fv3, fh3, fc3}, e.w3, e.v3, e.sync);
            else n_pass++;
            if (e.acc && e.r == 1 && e.c < 8) begin
                n_checks++;
                if (m3[5*DW +: DW] !== 16'(e.c))
                    $display("FAIL long_line_tap c%0d: got %h want %h", e.c, m3[5*DW +: DW], 16'(e.c));
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        sq.delete();
        push_vsync();
        for (int r = 0; r < 4; r++) push_line(r, 8, -1, 0, 1'b0);
        for (int i = 0; i < sq.size(); i++) begin
            step(sq[i]);
            n_checks++;
            if ((m3 & e.k3) !== (e.w3 & e.k3) || v3 !== e.v3 || {fv3, fh3, fc3} !== e.sync)
                $display("FAIL reset_mid_pre r%0d c%0d: mat=%h valid=%b want mat=%h valid=%b",
                         e.r, e.c, m3, v3, e.w3, e.v3);
            else n_pass++;
            if (p.acc && p.r == 3 && p.c == 4) break;
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (m3 !== '0 || m5 !== '0 || {fv3, fh3, fc3, v3, fv5, fh5, fc5, v5} !== 8'h00)
            $display("FAIL reset_mid_async: m3=%h m5=%h flags=%b want all zero", m3, m5, {fv3, fh3, fc3, v3, fv5, fh5, fc5, v5});
        else n_pass++;
        vsync = 1'b0; hsync = 1'b0; clken = 1'b0; data = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        sq.delete();
        push_vsync();
        for (int r = 0; r < 2; r++) push_line(r, 8, -1, 0, 1'b0);
        foreach (sq[i]) begin
            step(sq[i]);
            n_checks++;
            if ((m3 & e.k3) !== (e.w3 & e.k3) || v3 !== e.v3 || {fv3, fh3, fc3} !== e.sync)
                $display("FAIL reset_mid_post r%0d c%0d: mat=%h valid=%b sync=%b want mat=%h valid=%b sync=%b",
                         e.r, e.c, m3, v3, {fv3, fh3, fc3}, e.w3, e.v3, e.sync);
            else n_pass++;
            if (e.acc && e.r == 1 && e.c == 2) begin
                n_checks++;
                if (m3[47:0] !== 48'h0) $display("FAIL reset_mid_r1c2_top: got %h want 0", m3[47:0]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_ksize5();
        sq.delete();
        push_vsync();
        for (int r = 0; r < 6; r++) push_line(r, 8, -1, 0, 1'b0);
        foreach (sq[i]) begin
            step(sq[i]);
            n_checks++;
            if ((m5 & e.k5) !== (e.w5 & e.k5) || v5 !== e.v5 || {fv5, fh5, fc5} !== e.sync)
                $display("FAIL ksize5 r%0d c%0d: mat=%h valid=%b sync=%b want mat=%h valid=%b sync=%b",
                         e.r, e.c, m5, v5, {fv5, fh5, fc5}, e.w5, e.v5, e.sync);
            else n_pass++;
            if (e.acc && e.r == 4 && e.c == 4) begin
                n_checks++;
                if (m5[12*DW +: DW] !== 16'h0022 || v5 !== 1'b1)
                    $display("FAIL ksize5_centre: got %h valid=%b want 0022 valid=1", m5[12*DW +: DW], v5);
                else n_pass++;
            end
            if (e.acc && e.r == 3 && e.c == 4) begin
                n_checks++;
                if (v5 !== 1'b0) $display("FAIL ksize5_r3_valid: got %b want 0", v5);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            int rows;
            sq.delete();
            push_vsync();
            rows = int'($urandom_range(6, 3));
            for (int r = 0; r < rows; r++)
                push_line(r, int'($urandom_range(10, 5)), int'($urandom_range(7, 0)),
                          int'($urandom_range(3, 0)), 1'b1);
            foreach (sq[i]) begin
                step(sq[i]);
                n_checks++;
                if ((m3 & e.k3) !== (e.w3 & e.k3) || v3 !== e.v3 || {fv3, fh3, fc3} !== e.sync)
                    $display("FAIL random3 f%0d r%0d c%0d: mat=%h valid=%b sync=%b want mat=%h valid=%b sync=%b",
                             f, e.r, e.c, m3, v3, {fv3, fh3, fc3}, e.w3, e.v3, e.sync);
                else n_pass++;
                n_checks++;
                if ((m5 & e.k5) !== (e.w5 & e.k5) || v5 !== e.v5 || {fv5, fh5, fc5} !== e.sync)
                    $display("FAIL random5 f%0d r%0d c%0d: mat=%h valid=%b want mat=%h valid=%b",
                             f, e.r, e.c, m5, v5, e.w5, e.v5);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_second_frame();
        test_clken_gap();
        test_long_line();
        test_reset_mid();
        test_ksize5();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
